// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regfile
// Purpose  : I2C target with an 8-bit register file, auto-incrementing
//            pointer, optional clock stretching after every ACK bit.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR     = 7'h22,
    parameter int         MEM_DEPTH      = 16,
    parameter int         STRETCH_CYCLES = 0,
    localparam int        c_pw           = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            scl_i,
    input  logic            sda_i,
    output logic            scl_o,
    output logic            sda_o,
    output logic            mem_wr_o,
    output logic [c_pw-1:0] mem_addr_o,
    output logic [7:0]      mem_data_o,
    output logic            busy_o
);

    localparam logic [3:0] c_st_idle      = 4'd0;
    localparam logic [3:0] c_st_addr      = 4'd1;
    localparam logic [3:0] c_st_addr_ack  = 4'd2;
    localparam logic [3:0] c_st_ptr       = 4'd3;
    localparam logic [3:0] c_st_ptr_ack   = 4'd4;
    localparam logic [3:0] c_st_wdata     = 4'd5;
    localparam logic [3:0] c_st_wdata_ack = 4'd6;
    localparam logic [3:0] c_st_rdata     = 4'd7;
    localparam logic [3:0] c_st_rdata_ack = 4'd8;
    localparam logic [3:0] c_st_ignore    = 4'd9;

    logic [1:0]      r_scl_sync;
    logic [1:0]      r_sda_sync;
    logic            r_scl_q;
    logic            r_sda_q;
    logic [3:0]      r_state;
    logic [3:0]      w_next_state;
    logic [3:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [c_pw-1:0] r_ptr;
    logic [7:0]      r_mem [MEM_DEPTH];
    logic            r_sda_o;
    logic            r_mack;
    logic            r_mem_wr;
    logic [c_pw-1:0] r_mem_addr;
    logic [7:0]      r_mem_data;

    logic            w_scl;
    logic            w_sda;
    logic            w_scl_rise;
    logic            w_scl_fall;
    logic            w_start;
    logic            w_stop;
    logic            w_byte_done_fall;
    logic            w_addr_match;
    logic [7:0]      w_byte_in;
    logic [7:0]      w_rd_byte;

    // Two-flop synchronisers plus one history flop for edge/event detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_q    <= 1'b1;
            r_sda_q    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_i};
            r_sda_sync <= {r_sda_sync[0], sda_i};
            r_scl_q    <= r_scl_sync[1];
            r_sda_q    <= r_sda_sync[1];
        end
    end

    assign w_scl            = r_scl_sync[1];
    assign w_sda            = r_sda_sync[1];
    assign w_scl_rise       = w_scl & ~r_scl_q;
    assign w_scl_fall       = ~w_scl & r_scl_q;
    assign w_start          = w_scl & r_scl_q & ~w_sda & r_sda_q;
    assign w_stop           = w_scl & r_scl_q & w_sda & ~r_sda_q;
    assign w_byte_done_fall = w_scl_fall & (r_bit_cnt == 4'd8);
    assign w_addr_match     = (r_shift[7:1] == SLAVE_ADDR);
    assign w_byte_in        = {r_shift[6:0], w_sda};
    assign w_rd_byte        = r_mem[r_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // START/STOP win over every byte-level transition
    always_comb begin
        w_next_state = r_state;
        if (w_start) begin
            w_next_state = c_st_addr;
        end else if (w_stop) begin
            w_next_state = c_st_idle;
        end else begin
            case (r_state)
                c_st_addr: begin
                    if (w_byte_done_fall) begin
                        w_next_state = w_addr_match ? c_st_addr_ack : c_st_ignore;
                    end
                end
                c_st_addr_ack: begin
                    if (w_scl_fall) begin
                        w_next_state = r_shift[0] ? c_st_rdata : c_st_ptr;
                    end
                end
                c_st_ptr: begin
                    if (w_byte_done_fall) w_next_state = c_st_ptr_ack;
                end
                c_st_ptr_ack: begin
                    if (w_scl_fall) w_next_state = c_st_wdata;
                end
                c_st_wdata: begin
                    if (w_byte_done_fall) w_next_state = c_st_wdata_ack;
                end
                c_st_wdata_ack: begin
                    if (w_scl_fall) w_next_state = c_st_wdata;
                end
                c_st_rdata: begin
                    if (w_byte_done_fall) w_next_state = c_st_rdata_ack;
                end
                c_st_rdata_ack: begin
                    if (w_scl_fall) begin
                        w_next_state = r_mack ? c_st_rdata : c_st_ignore;
                    end
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        busy_o = 1'b0;
        case (r_state)
            c_st_addr_ack, c_st_ptr, c_st_ptr_ack, c_st_wdata,
            c_st_wdata_ack, c_st_rdata, c_st_rdata_ack: busy_o = 1'b1;
            default: busy_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_ptr      <= '0;
            r_sda_o    <= 1'b1;
            r_mack     <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem      <= '{default: 8'h00};
        end else begin
            r_mem_wr <= 1'b0;
            if (w_start || w_stop) begin
                r_bit_cnt <= '0;
                r_sda_o   <= 1'b1;
            end else begin
                case (r_state)
                    c_st_addr, c_st_ptr, c_st_wdata: begin
                        if (w_scl_rise && (r_bit_cnt < 4'd8)) begin
                            r_shift   <= w_byte_in;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            // Eighth data bit: commit pointer or register now
                            if (r_bit_cnt == 4'd7) begin
                                if (r_state == c_st_ptr) begin
                                    r_ptr <= w_byte_in[c_pw-1:0];
                                end else if (r_state == c_st_wdata) begin
                                    r_mem[r_ptr] <= w_byte_in;
                                    r_mem_wr     <= 1'b1;
                                    r_mem_addr   <= r_ptr;
                                    r_mem_data   <= w_byte_in;
                                    r_ptr        <= r_ptr + c_pw'(1);
                                end
                            end
                        end else if (w_byte_done_fall) begin
                            r_bit_cnt <= '0;
                            r_sda_o   <= (r_state == c_st_addr) ? ~w_addr_match : 1'b0;
                        end
                    end
                    c_st_addr_ack, c_st_ptr_ack, c_st_wdata_ack: begin
                        if (w_scl_fall) begin
                            if ((r_state == c_st_addr_ack) && r_shift[0]) begin
                                r_shift <= w_rd_byte;
                                r_sda_o <= w_rd_byte[7];
                            end else begin
                                r_sda_o <= 1'b1;
                            end
                        end
                    end
                    c_st_rdata: begin
                        if (w_scl_rise && (r_bit_cnt < 4'd8)) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && (r_bit_cnt != 4'd0)) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_bit_cnt <= '0;
                                r_sda_o   <= 1'b1;
                                r_ptr     <= r_ptr + c_pw'(1);
                            end else begin
                                r_shift <= {r_shift[6:0], 1'b0};
                                r_sda_o <= r_shift[6];
                            end
                        end
                    end
                    c_st_rdata_ack: begin
                        if (w_scl_rise) begin
                            r_mack <= ~w_sda;
                        end else if (w_scl_fall) begin
                            if (r_mack) begin
                                r_shift <= w_rd_byte;
                                r_sda_o <= w_rd_byte[7];
                            end else begin
                                r_sda_o <= 1'b1;
                            end
                        end
                    end
                    default: r_sda_o <= 1'b1;
                endcase
            end
        end
    end

    assign sda_o      = r_sda_o;
    assign mem_wr_o   = r_mem_wr;
    assign mem_addr_o = r_mem_addr;
    assign mem_data_o = r_mem_data;

    generate
        if (STRETCH_CYCLES > 0) begin : g_stretch
            localparam int c_cw = $clog2(STRETCH_CYCLES + 1);
            logic [c_cw-1:0] r_cnt;
            logic            r_scl;
            logic            w_ack_end;

            // The falling SCL edge that closes any ACK bit starts the hold
            assign w_ack_end = w_scl_fall &
                               ((r_state == c_st_addr_ack) || (r_state == c_st_ptr_ack) ||
                                (r_state == c_st_wdata_ack) || (r_state == c_st_rdata_ack));

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_cnt <= '0;
                    r_scl <= 1'b1;
                end else if (w_ack_end) begin
                    r_cnt <= c_cw'(STRETCH_CYCLES);
                    r_scl <= 1'b0;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - c_cw'(1);
                    if (r_cnt == c_cw'(1)) r_scl <= 1'b1;
                end
            end

            assign scl_o = r_scl;
        end else begin : g_no_stretch
            assign scl_o = 1'b1;
        end
    endgenerate

endmodule
`default_nettype wire
